// File: rtl/csr_bank.sv
// rtl/csr_bank.sv - Zicsr register bank with approximation CSRs and 64-bit mcycle/minstret counters
module csr_bank #(
  parameter int         NUM_APX     = 3,
  parameter logic [11:0] APX_BASE   = 12'h800,
  parameter bit         COUNTERS_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   csr_valid,
  input  logic [2:0]             funct3,
  input  logic [11:0]            csr_index,
  input  logic [31:0]            rs1_data,
  input  logic [4:0]             uimm,
  input  logic                   src_zero,
  input  logic                   instret_pulse,
  output logic [31:0]            rd_data,
  output logic                   illegal,
  output logic [NUM_APX*32-1:0]  apx_csr_flat
);

  logic [31:0] r_apx [NUM_APX];
  logic [63:0] r_mcycle;
  logic [63:0] r_minstret;
  logic        r_inh_cy;
  logic        r_inh_ir;

  logic [31:0]        w_operand;
  logic               w_op_ok;
  logic               w_wr_intent;
  logic [12:0]        w_apx_off;
  logic               w_apx_hit;
  logic [NUM_APX-1:0] w_apx_sel;
  logic               w_mapped;
  logic               w_ro;
  logic               w_sel_inh;
  logic               w_sel_mcyc_lo;
  logic               w_sel_mcyc_hi;
  logic               w_sel_minst_lo;
  logic               w_sel_minst_hi;
  logic [31:0]        w_old;
  logic [31:0]        w_new;
  logic               w_do_write;

  assign w_operand   = funct3[2] ? {27'b0, uimm} : rs1_data;
  assign w_op_ok     = (funct3[1:0] != 2'b00);
  // RW/RWI always write; set/clear forms with a zero source are pure reads
  assign w_wr_intent = (funct3[1:0] == 2'b01) || !src_zero;

  assign w_apx_off = {1'b0, csr_index} - {1'b0, APX_BASE};
  assign w_apx_hit = !w_apx_off[12] && (w_apx_off < 13'(NUM_APX));

  always_comb begin
    w_old          = 32'h0;
    w_mapped       = 1'b0;
    w_ro           = 1'b0;
    w_sel_inh      = 1'b0;
    w_sel_mcyc_lo  = 1'b0;
    w_sel_mcyc_hi  = 1'b0;
    w_sel_minst_lo = 1'b0;
    w_sel_minst_hi = 1'b0;
    w_apx_sel      = '0;
    for (int k = 0; k < NUM_APX; k++) begin
      if (w_apx_hit && (w_apx_off[3:0] == 4'(k))) begin
        w_apx_sel[k] = 1'b1;
        w_old        = r_apx[k];
        w_mapped     = 1'b1;
      end
    end
    if (COUNTERS_EN && !w_apx_hit) begin
      case (csr_index)
        12'h320: begin w_mapped = 1'b1; w_sel_inh = 1'b1; w_old = {29'b0, r_inh_ir, 1'b0, r_inh_cy}; end
        12'hB00: begin w_mapped = 1'b1; w_sel_mcyc_lo  = 1'b1; w_old = r_mcycle[31:0]; end
        12'hB80: begin w_mapped = 1'b1; w_sel_mcyc_hi  = 1'b1; w_old = r_mcycle[63:32]; end
        12'hB02: begin w_mapped = 1'b1; w_sel_minst_lo = 1'b1; w_old = r_minstret[31:0]; end
        12'hB82: begin w_mapped = 1'b1; w_sel_minst_hi = 1'b1; w_old = r_minstret[63:32]; end
        12'hC00: begin w_mapped = 1'b1; w_ro = 1'b1; w_old = r_mcycle[31:0]; end
        12'hC80: begin w_mapped = 1'b1; w_ro = 1'b1; w_old = r_mcycle[63:32]; end
        12'hC02: begin w_mapped = 1'b1; w_ro = 1'b1; w_old = r_minstret[31:0]; end
        12'hC82: begin w_mapped = 1'b1; w_ro = 1'b1; w_old = r_minstret[63:32]; end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (funct3[1:0])
      2'b10:   w_new = w_old | w_operand;
      2'b11:   w_new = w_old & ~w_operand;
      default: w_new = w_operand;
    endcase
  end

  assign illegal    = csr_valid && (!w_op_ok || !w_mapped || (w_wr_intent && w_ro));
  assign rd_data    = (csr_valid && !illegal) ? w_old : 32'h0;
  assign w_do_write = csr_valid && !illegal && w_wr_intent;

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_APX; k++) begin
      if (reset) begin
        r_apx[k] <= 32'h0;
      end else if (w_do_write && w_apx_sel[k]) begin
        r_apx[k] <= w_new;
      end
    end
  end

  for (genvar k = 0; k < NUM_APX; k++) begin : g_flat
    assign apx_csr_flat[32*k +: 32] = r_apx[k];
  end

  // A half-word write replaces the whole counter update for that cycle: no increment, no carry
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcycle   <= 64'h0;
      r_minstret <= 64'h0;
      r_inh_cy   <= 1'b0;
      r_inh_ir   <= 1'b0;
    end else begin
      if (w_do_write && w_sel_inh) begin
        r_inh_cy <= w_new[0];
        r_inh_ir <= w_new[2];
      end
      if (w_do_write && w_sel_mcyc_lo) begin
        r_mcycle[31:0] <= w_new;
      end else if (w_do_write && w_sel_mcyc_hi) begin
        r_mcycle[63:32] <= w_new;
      end else if (COUNTERS_EN && !r_inh_cy) begin
        r_mcycle <= r_mcycle + 64'd1;
      end
      if (w_do_write && w_sel_minst_lo) begin
        r_minstret[31:0] <= w_new;
      end else if (w_do_write && w_sel_minst_hi) begin
        r_minstret[63:32] <= w_new;
      end else if (COUNTERS_EN && !r_inh_ir && instret_pulse) begin
        r_minstret <= r_minstret + 64'd1;
      end
    end
  end

endmodule

// File: doc/csr_bank.md
# csr_bank

Parametrised control/status register bank for the phoeniX core, succeeding the fixed three-register approximation CSR file. It merges the CSR read-modify-write datapath (all six Zicsr ops) with a configurable number of approximation-control CSRs. It adds 64-bit mcycle/minstret counters with an inhibit register, read-only user shadows, and illegal-access detection. It sits in the execute stage beside the ALU, and its approximation CSR contents feed the ALU, multiplier and divider units directly.

## Interface
- NUM_APX, 3: number of approximation-control CSRs (1..16).
- APX_BASE, 12'h800: index of approximation CSR 0; CSR k is at APX_BASE+k (k=0 alucsr, 1 mulcsr, 2 divcsr).
- COUNTERS_EN, 1: 1 instantiates counters, shadows and mcountinhibit; 0 makes those indices unmapped.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- csr_valid  in  1  a CSR instruction is in execute this cycle.
- funct3  in  3  Zicsr op: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
- csr_index  in  12  target CSR address.
- rs1_data  in  32  source register value.
- uimm  in  5  zero-extended immediate for the I-forms.
- src_zero  in  1  rs1 field (or uimm) is zero.
- instret_pulse  in  1  one instruction retired this cycle.
- rd_data  out  32  old CSR value, to be written to rd.
- illegal  out  1  access is illegal; raises the illegal-instruction exception.
- apx_csr_flat  out  NUM_APX*32  concatenated approximation CSRs; CSR k occupies bits [32k+31:32k].

## Operation
- Operand: rs1_data for funct3[2]=0; {27'b0,uimm} for funct3[2]=1.
- New value:
  - RW: operand.
  - RS: old | operand.
  - RC: old & ~operand.
- Write intent:
  - RW and RWI always write.
  - RS, RC, RSI and RCI write only when src_zero=0.
- Map when COUNTERS_EN=1:
  - 0x320 mcountinhibit, read/write; only bits 0 (CY) and 2 (IR) are implemented, other bits read 0.
  - 0xB00/0xB80 mcycle low/high, read/write.
  - 0xB02/0xB82 minstret low/high, read/write.
  - 0xC00/0xC80 cycle and 0xC02/0xC82 instret, read-only shadows.
- illegal=1 (csr_valid high) when any of these holds:
  - funct3 is 000 or 100.
  - The index is unmapped.
  - Write intent targets a read-only index.
- On illegal: no state change and rd_data=0.
- When csr_valid=0: illegal=0, rd_data=0 and no write.
- rd_data is the pre-write value in every legal case, including pure reads.
- Counters:
  - mcycle increments by 1 every cycle when CY=0.
  - minstret increments by 1 on cycles where instret_pulse=1 and IR=0.
  - The increment is a full 64-bit increment; carry propagates low to high, and all-ones wraps to 0.
- Counter write in the same cycle as an increment: the CSR write wins for the written half. The other half keeps its current value, with no carry applied that cycle.
- A write to mcountinhibit takes effect for increments from the next cycle.

## Timing
- rd_data and illegal are combinational from the inputs and current state, valid in the same cycle.
- A legal write updates the register at the next rising edge. A CSR access in the following cycle reads the new value; there are no hazards inside the block.
- apx_csr_flat is registered and reflects a write one cycle after the access cycle.
- reset=1 at an edge:
  - Every register clears to 0: approximation CSRs, mcycle, minstret, mcountinhibit.
  - Reset overrides any simultaneous write or increment.
  - rd_data/illegal follow the combinational rules; apx_csr_flat reads 0 after the edge.
- First cycle after reset deasserts: mcycle reads 0; it reads 1 one cycle later.
- Back-to-back csr_valid cycles are fully supported; each is an independent one-cycle operation.

## Test plan
- Reset, then CSRRW index 0x801 with rs1_data=0xA5A5_0003 -> rd_data=0. Next cycle apx_csr_flat[63:32]=0xA5A5_0003, and CSRRS with src_zero=1 returns 0xA5A5_0003 with no write.
- Write 0x801=0xA5A5_0003 (as above), then CSRRCI uimm=5'h01 -> rd_data=0xA5A5_0003, new value 0xA5A5_0002. Then CSRRSI uimm=5'h10 -> value 0xA5A5_0012.
- Write mcycle low=0xFFFF_FFFE, high=0 -> the value increments: reads 0xFFFF_FFFF, then low=0 and high=1 the cycle after. CSRRW to 0xB80 during a carry cycle -> high takes the written value, no carry.
- CSRRW to 0xC00 -> illegal=1, rd_data=0, counters unchanged. CSRRS 0xC00 with src_zero=1 -> legal, returns the mcycle low value. Access to 0x7FF and funct3=100 -> illegal=1.
- Set mcountinhibit=0x5, pulse instret_pulse for 10 cycles -> mcycle and minstret frozen. Clear it -> both resume; minstret counts only pulsed cycles.
- Assert reset in the same cycle as CSRRW 0x800=0x1234 -> after the edge every CSR is 0 and apx_csr_flat=0.
